// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, flag bit positions, legality check and the
// command sequencer's state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_NOT = 4'h7;

  localparam int FLAG_OF = 3;
  localparam int FLAG_SF = 2;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_CF = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= ALU_ADD) && (op <= ALU_NOT);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth, wrapping pointers, occupancy count
// and a head entry that is readable without popping.
module alu_cmd_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage carries no reset; only entries behind a valid pointer are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the registered ALU: queues {opcode,A,B}, issues one
// command at a time and returns each result with its raw flags on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [3:0]             IN_OPCODE,
  input  logic [WIDTH-1:0]       IN_A,
  input  logic [WIDTH-1:0]       IN_B,
  output logic                   ALU_EN,
  output logic                   ALU_OE,
  output logic [3:0]             ALU_OPCODE,
  output logic [WIDTH-1:0]       ALU_A,
  output logic [WIDTH-1:0]       ALU_B,
  input  logic [WIDTH-1:0]       ALU_RESULT,
  input  logic [3:0]             ALU_FLAGS,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [WIDTH-1:0]       RES_DATA,
  output logic [3:0]             RES_FLAGS,
  output logic                   RES_ILLEGAL,
  output logic [$clog2(DEPTH):0] COUNT
);
  import alu_pkg::*;

  localparam int CMD_W = 4 + 2*WIDTH;

  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  seq_state_t       state_q,     state_d;
  logic [3:0]       alu_op_q,    alu_op_d;
  logic [WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             res_ill_q,   res_ill_d;

  // Ready depends only on registered occupancy, never on the result side.
  assign IN_READY   = !fifo_full;
  assign push       = IN_VALID && IN_READY;
  assign fifo_wdata = {IN_OPCODE, IN_A, IN_B};
  assign {head_op, head_a, head_b} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (COUNT)
  );

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_ill_d   = res_ill_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // Illegal opcodes never reach the ALU; they complete with a zeroed result.
          if (is_legal_op(head_op)) begin
            state_d  = S_ISSUE;
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
          end else begin
            state_d     = S_DONE;
            res_data_d  = '0;
            res_flags_d = '0;
            res_ill_d   = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d     = S_DONE;
        res_data_d  = ALU_RESULT;
        res_flags_d = ALU_FLAGS;
        res_ill_d   = 1'b0;
      end
      S_DONE: begin
        if (RES_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_ill_q   <= res_ill_d;
    end
  end

  assign ALU_EN      = (state_q == S_ISSUE);
  assign ALU_OE      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign ALU_OPCODE  = alu_op_q;
  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign RES_VALID   = (state_q == S_DONE);
  assign RES_DATA    = res_data_q;
  assign RES_FLAGS   = res_flags_q;
  assign RES_ILLEGAL = res_ill_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer with a behavioural stand-in for
// the registered unsigned ALU and a queue-based model of expected results.
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   RST_N;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [3:0]             IN_OPCODE;
  logic [WIDTH-1:0]       IN_A;
  logic [WIDTH-1:0]       IN_B;
  logic                   ALU_EN;
  logic                   ALU_OE;
  logic [3:0]             ALU_OPCODE;
  logic [WIDTH-1:0]       ALU_A;
  logic [WIDTH-1:0]       ALU_B;
  logic [WIDTH-1:0]       ALU_RESULT;
  logic [3:0]             ALU_FLAGS;
  logic                   RES_VALID;
  logic                   RES_READY;
  logic [WIDTH-1:0]       RES_DATA;
  logic [3:0]             RES_FLAGS;
  logic                   RES_ILLEGAL;
  logic [$clog2(DEPTH):0] COUNT;

  int passed = 0;
  int total  = 0;
  int en_cnt = 0;
  logic [12:0] exp_q [$];

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OPCODE(IN_OPCODE), .IN_A(IN_A), .IN_B(IN_B),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_RESULT(ALU_RESULT), .ALU_FLAGS(ALU_FLAGS),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS),
    .RES_ILLEGAL(RES_ILLEGAL), .COUNT(COUNT)
  );

  // Unsigned ALU behaviour: {OF,SF,ZF,CF, result}; SUB reports magnitude with SF/CF on borrow.
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       sf;
    logic       cf;
    r = 8'h00; sf = 1'b0; cf = 1'b0;
    case (op)
      4'h2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cf = s[8]; end
      4'h3: begin
        if (a < b) begin r = b - a; sf = 1'b1; cf = 1'b1; end
        else r = a - b;
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      default: r = 8'h00;
    endcase
    return {1'b0, sf, (r == 8'h00), cf, r};
  endfunction

  function automatic logic [12:0] ref_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op >= 4'h2 && op <= 4'h7) return {1'b0, alu_model(op, a, b)};
    return {1'b1, 12'h000};
  endfunction

  logic [7:0] alu_out_q = 8'h00;
  logic [3:0] alu_flg_q = 4'h0;
  always @(posedge CLK) begin
    if (ALU_EN) {alu_flg_q, alu_out_q} <= alu_model(ALU_OPCODE, ALU_A, ALU_B);
  end
  assign ALU_RESULT = ALU_OE ? alu_out_q : 8'h00;
  assign ALU_FLAGS  = ALU_OE ? alu_flg_q : 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Each new result is matched to the oldest outstanding command and must stay put while valid.
  logic [12:0] cur_exp  = 13'h0;
  logic        prev_vld = 1'b0;
  always @(negedge CLK) begin
    if (ALU_EN) en_cnt++;
    if (RES_VALID) begin
      if (!prev_vld) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else cur_exp = exp_q.pop_front();
      end
      check("result", 32'({RES_ILLEGAL, RES_FLAGS, RES_DATA}), 32'(cur_exp));
    end
    prev_vld = RES_VALID;
  end

  task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output logic acc);
    IN_VALID = 1'b1; IN_OPCODE = op; IN_A = a; IN_B = b;
    acc = IN_READY;
    if (acc) exp_q.push_back(ref_result(op, a, b));
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !RES_VALID && COUNT == 0 && !ALU_OE) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(RES_VALID),   32'd0);
    check({tag, "_data"},    32'(RES_DATA),    32'd0);
    check({tag, "_flags"},   32'(RES_FLAGS),   32'd0);
    check({tag, "_illegal"}, 32'(RES_ILLEGAL), 32'd0);
    check({tag, "_en"},      32'(ALU_EN),      32'd0);
    check({tag, "_oe"},      32'(ALU_OE),      32'd0);
    check({tag, "_opcode"},  32'(ALU_OPCODE),  32'd0);
    check({tag, "_a"},       32'(ALU_A),       32'd0);
    check({tag, "_b"},       32'(ALU_B),       32'd0);
    check({tag, "_ready"},   32'(IN_READY),    32'd1);
    check({tag, "_count"},   32'(COUNT),       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   n_acc;
    int   n_legal;
    int   e0;
    logic [3:0] op;

    RST_N = 1'b0; IN_VALID = 1'b0; IN_OPCODE = 4'h0; IN_A = 8'h00; IN_B = 8'h00; RES_READY = 1'b1;

    // Reset held for two clocks, then released.
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst_hold");
    RST_N = 1'b1;
    @(negedge CLK);
    check_reset_outputs("rst_release");

    // ADD 5+3: accepted, then valid in the fourth cycle counting the accept cycle.
    drive_cmd(4'h2, 8'h05, 8'h03, acc);
    check("add_accept", 32'(acc), 32'd1);
    check("add_count1", 32'(COUNT), 32'd1);
    check("add_lat_c1", 32'(RES_VALID), 32'd0);
    @(negedge CLK);
    check("add_issue_en", 32'(ALU_EN), 32'd1);
    check("add_issue_oe", 32'(ALU_OE), 32'd1);
    check("add_issue_op", 32'(ALU_OPCODE), 32'h2);
    check("add_issue_a",  32'(ALU_A), 32'h05);
    check("add_issue_b",  32'(ALU_B), 32'h03);
    check("add_count0",   32'(COUNT), 32'd0);
    @(negedge CLK);
    check("add_wait_en",  32'(ALU_EN), 32'd0);
    check("add_wait_oe",  32'(ALU_OE), 32'd1);
    check("add_lat_c3",   32'(RES_VALID), 32'd0);
    @(negedge CLK);
    check("add_valid",    32'(RES_VALID), 32'd1);
    check("add_data",     32'(RES_DATA), 32'h08);
    check("add_flags",    32'(RES_FLAGS), 32'h0);
    check("add_oe_done",  32'(ALU_OE), 32'd0);
    check("add_op_held",  32'(ALU_OPCODE), 32'h2);
    @(negedge CLK);
    check("add_consumed", 32'(RES_VALID), 32'd0);

    drive_cmd(4'h3, 8'h03, 8'h05, acc);
    repeat (3) @(negedge CLK);
    check("sub_valid", 32'(RES_VALID), 32'd1);
    check("sub_data",  32'(RES_DATA), 32'h02);
    check("sub_flags", 32'(RES_FLAGS), 32'b0101);
    wait_idle(20, "sub_idle");

    // Backpressure: six back-to-back pushes, one goes in flight and four queue.
    RES_READY = 1'b0;
    e0 = en_cnt;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(4'($urandom_range(2, 7)), 8'($urandom), 8'($urandom), acc);
      n_acc += int'(acc);
    end
    check("bp_accepted", 32'(n_acc), 32'd5);
    check("bp_ready",    32'(IN_READY), 32'd0);
    check("bp_count",    32'(COUNT), 32'd4);
    RES_READY = 1'b1;
    wait_idle(200, "bp_drain");
    check("bp_en_pulses", 32'(en_cnt - e0), 32'd5);

    // Illegal opcode completes in the second cycle without touching the ALU.
    e0 = en_cnt;
    drive_cmd(4'hF, 8'($urandom), 8'($urandom), acc);
    check("ill_lat_c1", 32'(RES_VALID), 32'd0);
    @(negedge CLK);
    check("ill_valid",   32'(RES_VALID), 32'd1);
    check("ill_flag",    32'(RES_ILLEGAL), 32'd1);
    check("ill_data",    32'(RES_DATA), 32'h00);
    check("ill_flags",   32'(RES_FLAGS), 32'h0);
    check("ill_oe",      32'(ALU_OE), 32'd0);
    check("ill_no_en",   32'(en_cnt - e0), 32'd0);
    wait_idle(20, "ill_idle");

    // Result held in DONE for ten cycles while another command waits behind it.
    RES_READY = 1'b0;
    drive_cmd(4'($urandom_range(2, 7)), 8'($urandom), 8'($urandom), acc);
    drive_cmd(4'($urandom_range(2, 7)), 8'($urandom), 8'($urandom), acc);
    for (int i = 0; i < 8 && !RES_VALID; i++) @(negedge CLK);
    check("hold_reached", 32'(RES_VALID), 32'd1);
    e0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("hold_valid", 32'(RES_VALID), 32'd1);
    end
    check("hold_no_en", 32'(en_cnt - e0), 32'd0);
    check("hold_count", 32'(COUNT), 32'd1);
    RES_READY = 1'b1;
    wait_idle(40, "hold_idle");

    // Reset while a command is in WAIT with three more queued.
    RES_READY = 1'b0;
    for (int i = 0; i < 5; i++)
      drive_cmd(4'($urandom_range(2, 7)), 8'($urandom), 8'($urandom), acc);
    check("mid_full", 32'(COUNT), 32'd4);
    RES_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check("mid_wait_oe",  32'(ALU_OE), 32'd1);
    check("mid_wait_en",  32'(ALU_EN), 32'd0);
    check("mid_queued",   32'(COUNT), 32'd3);
    RST_N = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    check("mid_rst_count", 32'(COUNT), 32'd0);
    check("mid_rst_oe",    32'(ALU_OE), 32'd0);
    check("mid_rst_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_ready", 32'(IN_READY), 32'd1);
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("mid_no_result", 32'(RES_VALID), 32'd0);
      check("mid_no_en",     32'(ALU_EN), 32'd0);
    end

    // Random opcodes, operands and consumer stalls.
    e0 = en_cnt;
    n_legal = 0;
    for (int i = 0; i < 30; i++) begin
      RES_READY = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      drive_cmd(op, 8'($urandom), 8'($urandom), acc);
      if (acc && op >= 4'h2 && op <= 4'h7) n_legal++;
    end
    RES_READY = 1'b1;
    wait_idle(400, "rand_drain");
    check("rand_en_pulses", 32'(en_cnt - e0), 32'(n_legal));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
